empaque_calcetines: RTL and testbench
=====================================

EMPAQUE_CALCETINES -- requirements
Module: empaque_calcetines

Interface
REQ-001 Parameter PACK_SIZE, default 6, socks per box (range 2..7).
REQ-002 Parameter SEAL_CYC, default 2, cycles the sealer is active per box (range 1..7).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  accept enable; when 0, sock pulses are ignored.
REQ-006 sock_bajo  input  1  one-cycle pulse per finished low sock from the fabrication FSM.
REQ-007 sock_alto  input  1  one-cycle pulse per finished high sock from the fabrication FSM.
REQ-008 box_ready  input  1  downstream conveyor can take a box this cycle.
REQ-009 box_valid  output  1  a sealed box is presented to the conveyor.
REQ-010 box_type  output  1  type of presented box: 0 = bajo, 1 = alto.
REQ-011 sellar  output  1  sealer actuator on.
REQ-012 acc_bajo  output  3  low socks currently waiting in the bajo tray.
REQ-013 acc_alto  output  3  high socks currently waiting in the alto tray.
REQ-014 cajas_bajo  output  8  bajo boxes delivered, modulo 256.
REQ-015 cajas_alto  output  8  alto boxes delivered, modulo 256.
REQ-016 overflow  output  1  sticky: a sock was lost to a full tray.
REQ-017 estado  output  2  FSM state code: IDLE=00, SEAL=01, PUSH=10.

Function
REQ-018 All outputs shall be registered; no combinational path from any input to any output.
REQ-019 With en=1, each sock_bajo / sock_alto pulse shall increment its tray count by 1 at the next edge; simultaneous pulses shall both be counted.
REQ-020 A tray is full when its count equals PACK_SIZE; a pulse into a full tray shall be dropped and set overflow=1 until reset.
REQ-021 Trays shall keep accepting socks in every FSM state (SEAL and PUSH included).
REQ-022 IDLE: if acc_bajo==PACK_SIZE go to SEAL with type 0; else if acc_alto==PACK_SIZE go to SEAL with type 1; else stay; bajo has priority when both are full.
REQ-023 On the IDLE->SEAL edge the selected tray shall be set to 0, or to 1 if a pulse of that type arrives in the same cycle.
REQ-024 SEAL: sellar=1 for exactly SEAL_CYC cycles, then go to PUSH; box_type latched on SEAL entry and held until return to IDLE.
REQ-025 PUSH: box_valid=1; box_type stable; leave only on an edge where box_valid=1 and box_ready=1, then go to IDLE.
REQ-026 box_valid shall be 0 in IDLE and SEAL; box_ready is ignored outside PUSH.
REQ-027 On each transfer the counter for box_type shall increment by 1, wrapping 255->0.
REQ-028 Minimum box period: 1 IDLE + SEAL_CYC + 1 PUSH cycles = 4 cycles at defaults.
REQ-029 en=0 shall not abort a box in SEAL or PUSH; the FSM completes the current box.
REQ-030 The unused state code 11 shall return to IDLE on the next edge with outputs as in IDLE.

Reset
REQ-031 reset=0 shall immediately force state IDLE, box_valid=0, box_type=0, sellar=0, acc_bajo=0, acc_alto=0, cajas_bajo=0, cajas_alto=0, overflow=0, seal counter 0.
REQ-032 reset asserted mid-SEAL or mid-PUSH shall discard the box, with no count increment.
REQ-033 After reset deasserts, the first edge shall behave as IDLE with empty trays.

Verification
REQ-034 Six sock_bajo pulses, box_ready=1 -> acc_bajo 1..6, SEAL with sellar=1 for 2 cycles, box_valid=1 with box_type=0 for 1 cycle, cajas_bajo=1, acc_bajo=0.
REQ-035 Both trays at 6 in the same cycle -> bajo box first, then alto box; cajas_bajo=1, cajas_alto=1; no overflow.
REQ-036 box_ready=0 for 5 cycles in PUSH -> box_valid and box_type held for 5 cycles; one transfer on the first edge with box_ready=1.
REQ-037 acc_alto=6 held in PUSH of a bajo box, one more sock_alto -> acc_alto stays 6, overflow=1 and stays 1 until reset.
REQ-038 reset=0 during the second SEAL cycle -> all outputs zero immediately; cajas unchanged at 0; next six sock_bajo produce a normal box.
REQ-039 256 bajo boxes delivered -> cajas_bajo wraps to 0; en=0 with pulses -> acc counts unchanged.

Source files
------------

// File: rtl/empaque_calcetines.sv
// ---------------------------------------------------------------------------
// empaque_calcetines
//
// Sock packing cell. Counts finished low ("bajo") and high ("alto") socks
// into two trays. When a tray holds PACK_SIZE socks it is emptied into a box.
// The box is sealed for SEAL_CYC cycles and then presented to the downstream
// conveyor with a valid/ready handshake. Every output is a flop, so there is
// no combinational path from any input to any output.
//
// Parameters
//   PACK_SIZE   socks per box (2..7)
//   SEAL_CYC    cycles the sealer stays on for each box (1..7)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low (0 = in reset)
//   en          accept enable for sock pulses
//   sock_bajo   one-cycle pulse per finished low sock
//   sock_alto   one-cycle pulse per finished high sock
//   box_ready   conveyor can take a box this cycle
//   box_valid   sealed box presented to the conveyor
//   box_type    type of the current box (0 = bajo, 1 = alto)
//   sellar      sealer actuator on
//   acc_bajo    low socks waiting in the bajo tray
//   acc_alto    high socks waiting in the alto tray
//   cajas_bajo  bajo boxes delivered, modulo 256
//   cajas_alto  alto boxes delivered, modulo 256
//   overflow    sticky flag: a sock was lost to a full tray
//   estado      FSM state code (IDLE=00, SEAL=01, PUSH=10)
// ---------------------------------------------------------------------------
module empaque_calcetines #(
    parameter int PACK_SIZE = 6,
    parameter int SEAL_CYC  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sock_bajo,
    input  logic       sock_alto,
    input  logic       box_ready,
    output logic       box_valid,
    output logic       box_type,
    output logic       sellar,
    output logic [2:0] acc_bajo,
    output logic [2:0] acc_alto,
    output logic [7:0] cajas_bajo,
    output logic [7:0] cajas_alto,
    output logic       overflow,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEAL   = 2'b01,
        PUSH   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    localparam logic [2:0] PACK      = 3'(PACK_SIZE);
    localparam logic [2:0] SEAL_LAST = 3'(SEAL_CYC);

    state_t     state_q, state_d;
    logic [2:0] seal_cnt_q, seal_cnt_d;
    logic       box_type_q, box_type_d;
    logic       box_valid_q, box_valid_d;
    logic       sellar_q, sellar_d;
    logic [2:0] acc_bajo_q, acc_bajo_d;
    logic [2:0] acc_alto_q, acc_alto_d;
    logic [7:0] cajas_bajo_q, cajas_bajo_d;
    logic [7:0] cajas_alto_q, cajas_alto_d;
    logic       overflow_q, overflow_d;

    logic       start_bajo, start_alto;
    logic       take_bajo, take_alto;

    assign take_bajo = en & sock_bajo;
    assign take_alto = en & sock_alto;

    // Box sequencing. seal_cnt counts the SEAL cycles already spent,
    // starting at 1 on entry, so the last SEAL cycle is seal_cnt==SEAL_CYC.
    always_comb begin
        state_d      = state_q;
        seal_cnt_d   = seal_cnt_q;
        box_type_d   = box_type_q;
        cajas_bajo_d = cajas_bajo_q;
        cajas_alto_d = cajas_alto_q;
        start_bajo   = 1'b0;
        start_alto   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_bajo_q == PACK) begin
                    state_d    = SEAL;
                    seal_cnt_d = 3'd1;
                    box_type_d = 1'b0;
                    start_bajo = 1'b1;
                end else if (acc_alto_q == PACK) begin
                    state_d    = SEAL;
                    seal_cnt_d = 3'd1;
                    box_type_d = 1'b1;
                    start_alto = 1'b1;
                end
            end
            SEAL: begin
                if (seal_cnt_q == SEAL_LAST) begin
                    state_d    = PUSH;
                    seal_cnt_d = 3'd0;
                end else begin
                    seal_cnt_d = seal_cnt_q + 3'd1;
                end
            end
            PUSH: begin
                if (box_ready) begin
                    state_d = IDLE;
                    if (box_type_q) begin
                        cajas_alto_d = cajas_alto_q + 8'd1;
                    end else begin
                        cajas_bajo_d = cajas_bajo_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                seal_cnt_d = 3'd0;
            end
        endcase

        // Flag outputs are derived from the next state so they line up
        // with estado after the edge.
        sellar_d    = (state_d == SEAL);
        box_valid_d = (state_d == PUSH);
    end

    // Trays keep filling regardless of FSM state. The tray being boxed
    // restarts at 0, or at 1 when a sock of that type lands in the same cycle.
    always_comb begin
        acc_bajo_d = acc_bajo_q;
        acc_alto_d = acc_alto_q;
        overflow_d = overflow_q;

        if (start_bajo) begin
            acc_bajo_d = take_bajo ? 3'd1 : 3'd0;
        end else if (take_bajo) begin
            if (acc_bajo_q == PACK) begin
                overflow_d = 1'b1;
            end else begin
                acc_bajo_d = acc_bajo_q + 3'd1;
            end
        end

        if (start_alto) begin
            acc_alto_d = take_alto ? 3'd1 : 3'd0;
        end else if (take_alto) begin
            if (acc_alto_q == PACK) begin
                overflow_d = 1'b1;
            end else begin
                acc_alto_d = acc_alto_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            seal_cnt_q   <= 3'd0;
            box_type_q   <= 1'b0;
            box_valid_q  <= 1'b0;
            sellar_q     <= 1'b0;
            acc_bajo_q   <= 3'd0;
            acc_alto_q   <= 3'd0;
            cajas_bajo_q <= 8'd0;
            cajas_alto_q <= 8'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seal_cnt_q   <= seal_cnt_d;
            box_type_q   <= box_type_d;
            box_valid_q  <= box_valid_d;
            sellar_q     <= sellar_d;
            acc_bajo_q   <= acc_bajo_d;
            acc_alto_q   <= acc_alto_d;
            cajas_bajo_q <= cajas_bajo_d;
            cajas_alto_q <= cajas_alto_d;
            overflow_q   <= overflow_d;
        end
    end

    assign box_valid  = box_valid_q;
    assign box_type   = box_type_q;
    assign sellar     = sellar_q;
    assign acc_bajo   = acc_bajo_q;
    assign acc_alto   = acc_alto_q;
    assign cajas_bajo = cajas_bajo_q;
    assign cajas_alto = cajas_alto_q;
    assign overflow   = overflow_q;
    assign estado     = state_q;

endmodule

// File: tb/tb_empaque_calcetines.sv
// ---------------------------------------------------------------------------
// tb_empaque_calcetines
//
// Bench for empaque_calcetines at default parameters. A transaction-level
// model (tray counts, box age in cycles since it started) predicts every
// output and is compared against the DUT on each falling edge. Directed
// sequences add literal expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_empaque_calcetines;

    localparam int PACK = 6;
    localparam int SC   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       sock_bajo;
    logic       sock_alto;
    logic       box_ready;
    logic       box_valid;
    logic       box_type;
    logic       sellar;
    logic [2:0] acc_bajo;
    logic [2:0] acc_alto;
    logic [7:0] cajas_bajo;
    logic [7:0] cajas_alto;
    logic       overflow;
    logic [1:0] estado;

    always #5 clk = ~clk;

    empaque_calcetines #(
        .PACK_SIZE (PACK),
        .SEAL_CYC  (SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sock_bajo  (sock_bajo),
        .sock_alto  (sock_alto),
        .box_ready  (box_ready),
        .box_valid  (box_valid),
        .box_type   (box_type),
        .sellar     (sellar),
        .acc_bajo   (acc_bajo),
        .acc_alto   (acc_alto),
        .cajas_bajo (cajas_bajo),
        .cajas_alto (cajas_alto),
        .overflow   (overflow),
        .estado     (estado)
    );

    int pass_count  = 0;
    int check_count = 0;
    bit compare_on  = 1'b0;

    // Model state: trays, delivered boxes, and the box in progress described
    // by its age (1 on the first sealing cycle).
    int m_tray[2]  = '{0, 0};
    int m_cajas[2] = '{0, 0};
    int m_total[2] = '{0, 0};
    bit m_busy     = 1'b0;
    int m_age      = 0;
    bit m_type     = 1'b0;
    bit m_ovf      = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_tray[k]  = 0;
            m_cajas[k] = 0;
            m_total[k] = 0;
        end
        m_busy = 1'b0;
        m_age  = 0;
        m_type = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit take[2];
        bit start;
        int sel;
        take[0] = en && sock_bajo;
        take[1] = en && sock_alto;
        start = 1'b0;
        sel = 0;
        if (!m_busy) begin
            if (m_tray[0] == PACK) begin
                start = 1'b1;
                sel = 0;
            end else if (m_tray[1] == PACK) begin
                start = 1'b1;
                sel = 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (start && sel == k) begin
                m_tray[k] = take[k] ? 1 : 0;
            end else if (take[k]) begin
                if (m_tray[k] == PACK) m_ovf = 1'b1;
                else m_tray[k]++;
            end
        end
        if (m_busy) begin
            if (m_age > SC && box_ready) begin
                m_cajas[m_type] = (m_cajas[m_type] + 1) % 256;
                m_total[m_type]++;
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
        if (start) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_type = sel[0];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else model_step();
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (compare_on) begin
                checkOutput("cmp_sellar",    int'(sellar),     int'(m_busy && m_age <= SC));
                checkOutput("cmp_box_valid", int'(box_valid),  int'(m_busy && m_age > SC));
                checkOutput("cmp_box_type",  int'(box_type),   int'(m_type));
                checkOutput("cmp_estado",    int'(estado),     !m_busy ? 0 : (m_age <= SC ? 1 : 2));
                checkOutput("cmp_acc_bajo",  int'(acc_bajo),   m_tray[0]);
                checkOutput("cmp_acc_alto",  int'(acc_alto),   m_tray[1]);
                checkOutput("cmp_cajas_bajo",int'(cajas_bajo), m_cajas[0]);
                checkOutput("cmp_cajas_alto",int'(cajas_alto), m_cajas[1]);
                checkOutput("cmp_overflow",  int'(overflow),   int'(m_ovf));
            end
        end
    end

    // Drive one cycle of inputs from a falling edge; returns on the next one.
    task automatic applyStimulus(input bit e, input bit sb, input bit sa, input bit rdy);
        en        = e;
        sock_bajo = sb;
        sock_alto = sa;
        box_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        en        = 1'b0;
        sock_bajo = 1'b0;
        sock_alto = 1'b0;
        box_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int guard;
        reset     = 1'b1;
        en        = 1'b0;
        sock_bajo = 1'b0;
        sock_alto = 1'b0;
        box_ready = 1'b0;
        @(negedge clk);
        do_reset();
        compare_on = 1'b1;

        // Reset values
        checkOutput("rst_estado",     int'(estado), 0);
        checkOutput("rst_acc_bajo",   int'(acc_bajo), 0);
        checkOutput("rst_cajas_bajo", int'(cajas_bajo), 0);
        checkOutput("rst_overflow",   int'(overflow), 0);

        // Single bajo box, conveyor always ready
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 1, 0, 1);
            checkOutput($sformatf("fill_bajo_%0d", i), int'(acc_bajo), i);
        end
        applyStimulus(1, 0, 0, 1);
        checkOutput("b1_seal1_sellar", int'(sellar), 1);
        checkOutput("b1_seal1_estado", int'(estado), 1);
        checkOutput("b1_seal1_acc",    int'(acc_bajo), 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("b1_seal2_sellar", int'(sellar), 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("b1_push_valid",   int'(box_valid), 1);
        checkOutput("b1_push_sellar",  int'(sellar), 0);
        checkOutput("b1_push_type",    int'(box_type), 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("b1_done_cajas",   int'(cajas_bajo), 1);
        checkOutput("b1_done_valid",   int'(box_valid), 0);
        checkOutput("b1_done_estado",  int'(estado), 0);

        // Both trays full together: bajo first, then alto
        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("both_bajo_done",  int'(cajas_bajo), 1);
        checkOutput("both_idle_gap",   int'(estado), 0);
        checkOutput("both_alto_wait",  int'(acc_alto), 6);
        applyStimulus(1, 0, 0, 1);
        checkOutput("both_alto_seal",  int'(estado), 1);
        checkOutput("both_alto_type",  int'(box_type), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("both_alto_done",  int'(cajas_alto), 1);
        checkOutput("both_no_ovf",     int'(overflow), 0);

        // Backpressure: ready low for 5 PUSH cycles
        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), int'(box_valid), 1);
            checkOutput($sformatf("bp_cajas_%0d", i), int'(cajas_bajo), 0);
            applyStimulus(1, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 1);
        checkOutput("bp_transfer",     int'(cajas_bajo), 1);
        checkOutput("bp_valid_low",    int'(box_valid), 0);

        // Overflow into the full alto tray during a bajo PUSH
        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("ovf_in_push",     int'(box_valid), 1);
        applyStimulus(1, 0, 1, 0);
        checkOutput("ovf_acc_alto",    int'(acc_alto), 6);
        checkOutput("ovf_set",         int'(overflow), 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("ovf_alto_box",    int'(cajas_alto), 1);
        checkOutput("ovf_sticky",      int'(overflow), 1);
        do_reset();
        checkOutput("ovf_cleared",     int'(overflow), 0);

        // Reset during the second SEAL cycle
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("mid_seal2",       int'(sellar), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_sellar",  int'(sellar), 0);
        checkOutput("mid_rst_estado",  int'(estado), 0);
        checkOutput("mid_rst_cajas",   int'(cajas_bajo), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("mid_rst_after",   int'(cajas_bajo), 1);

        // en=0 ignores pulses
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("en0_acc_bajo",    int'(acc_bajo), 3);
        checkOutput("en0_acc_alto",    int'(acc_alto), 0);

        // Counter wrap after 256 bajo boxes
        do_reset();
        guard = 0;
        while (m_total[0] < 255 && guard < 3000) begin
            applyStimulus(1, 1, 0, 1);
            guard++;
        end
        checkOutput("wrap_255",        int'(cajas_bajo), 255);
        while (m_total[0] < 256 && guard < 3000) begin
            applyStimulus(1, 1, 0, 1);
            guard++;
        end
        checkOutput("wrap_0",          int'(cajas_bajo), 0);
        checkOutput("wrap_in_budget",  int'(guard < 3000), 1);
        applyStimulus(0, 0, 0, 1);

        compare_on = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
